data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder_pkg.sv | 33 +++
 rtl/data_sram_responder_if.sv | 24 ++
 rtl/data_sram_responder_resp_queue.sv | 70 +++++++
 rtl/data_sram_responder.sv | 78 +++++++
 tb/tb_data_sram_responder.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared types for the data-side SRAM responder: request entry layout, size codes
// and the byte-lane merge used by both the RAM write path and anything modelling it.
package data_sram_responder_pkg;

  typedef enum logic [1:0] {
    SRAM_SIZE_B = 2'd0,
    SRAM_SIZE_H = 2'd1,
    SRAM_SIZE_W = 2'd2
  } sram_size_e;

  typedef struct packed {
    logic       wr;
    sram_size_e size;
    logic [3:0] wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

  localparam int SRAM_CNT_WD      = 4;
  localparam int SRAM_RESP_ENT_WD = 1 + 2 + 4 + 32 + 32 + SRAM_CNT_WD;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// SRAM-like data bus between the EXE initiator (master) and the memory responder (slave).
interface data_sram_responder_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_sram_responder_resp_queue.sv
// In-order pending-request FIFO; every live entry carries a countdown that reaches zero
// when its response may be issued, so the head is ready once its countdown has expired.
module data_sram_responder_resp_queue
  import data_sram_responder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  sram_req_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      head_ready_o,
  output sram_req_t head_data_o
);
  localparam int PW     = $clog2(DEPTH);
  localparam int PAY_WD = SRAM_RESP_ENT_WD - SRAM_CNT_WD;
  localparam logic [SRAM_CNT_WD-1:0] CNT_INIT = SRAM_CNT_WD'(LAT - 1);

  logic [PAY_WD-1:0]      data_q [DEPTH];
  logic [SRAM_CNT_WD-1:0] cnt_q  [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [PW:0]            count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop_i)  head_d = head_q + PW'(1);
    if (push_i) tail_d = tail_q + PW'(1);
    if (push_i && !pop_i)      count_d = count_q + (PW+1)'(1);
    else if (pop_i && !push_i) count_d = count_q - (PW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Countdowns run for every live entry, not just the head, so a queued entry
      // that has already aged LAT cycles is ready the moment it reaches the head.
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_q[i] && cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
      if (pop_i) valid_q[head_q] <= 1'b0;
      if (push_i) begin
        valid_q[tail_q] <= 1'b1;
        cnt_q[tail_q]   <= CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) data_q[tail_q] <= push_data_i;
  end

  assign full_o       = (count_q == (PW+1)'(DEPTH));
  assign head_ready_o = valid_q[head_q] && (cnt_q[head_q] == '0);
  assign head_data_o  = sram_req_t'(data_q[head_q]);

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM bus responder: queues requests, answers in order after LAT cycles from a
// word-addressed RAM. Define RESP_STALL_EN to add LFSR-driven random addr_ok back-pressure.
module data_sram_responder
  import data_sram_responder_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int QDEPTH = 4,
  parameter int LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  data_sram_responder_if.slave bus
);
  sram_req_t          push_req;
  sram_req_t          head;
  logic               full;
  logic               head_ready;
  logic               accept;
  logic               stall;
  logic [MEM_AW-1:0]  ram_idx;
  logic [31:0]        mem_q [2**MEM_AW];
  logic               unused_bits;

`ifdef RESP_STALL_EN
  logic [31:0] lfsr_q, lfsr_d;

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= 32'h1;
    else       lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    push_req       = '0;
    push_req.wr    = bus.data_sram_wr;
    push_req.size  = sram_size_e'(bus.data_sram_size);
    push_req.wstrb = bus.data_sram_wstrb;
    push_req.addr  = bus.data_sram_addr;
    push_req.wdata = bus.data_sram_wdata;
  end

  // Depends on queue state only; a pop in the same cycle does not free a slot early.
  assign bus.data_sram_addr_ok = ~reset & ~full & ~stall;
  assign accept                = bus.data_sram_req & bus.data_sram_addr_ok;

  data_sram_responder_resp_queue #(
    .DEPTH (QDEPTH),
    .LAT   (LAT)
  ) u_queue (
    .clk          (clk),
    .rst          (reset),
    .push_i       (accept),
    .push_data_i  (push_req),
    .pop_i        (head_ready),
    .full_o       (full),
    .head_ready_o (head_ready),
    .head_data_o  (head)
  );

  assign ram_idx = head.addr[MEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (head_ready && head.wr) mem_q[ram_idx] <= merge_bytes(mem_q[ram_idx], head.wdata, head.wstrb);
  end

  assign bus.data_sram_data_ok = head_ready;
  assign bus.data_sram_rdata   = (head_ready && !head.wr) ? mem_q[ram_idx] : 32'h0;

  assign unused_bits = ^{head.size, head.addr[31:MEM_AW+2], head.addr[1:0]};

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized scoreboard bench for data_sram_responder: a word-array reference model predicts
// each response's data and its cycle; a negedge monitor pops and compares every data_ok.
module tb_data_sram_responder;
  localparam int MEM_AW = 10;
  localparam int QDEPTH = 4;
  localparam int LAT    = 5;
  localparam int NWORDS = 17;

  typedef struct {
    logic        wr;
    int          idx;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          exp_cyc;
    int          tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_sram_responder_if bus_if();

  data_sram_responder #(.MEM_AW(MEM_AW), .QDEPTH(QDEPTH), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus_if)
  );

  exp_t        sb[$];
  logic [31:0] m_mem [int];   // view of memory including every accepted write
  logic [31:0] c_mem [int];   // view including only writes that have responded
  int checks = 0, failures = 0, cyc = 0, last_exp = 0, occ = 0;
  int stall_seen = 0, ntag = 0, resp_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] apply_strb(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic wr, input logic [3:0] wstrb, input logic [31:0] addr,
                       input logic [31:0] wdata);
    exp_t e;
    int   waited;
    int   idx;
    logic [31:0] old_w;
    waited = 0;
    bus_if.data_sram_req   = 1'b1;
    bus_if.data_sram_wr    = wr;
    bus_if.data_sram_size  = 2'($urandom_range(0, 2));
    bus_if.data_sram_wstrb = wstrb;
    bus_if.data_sram_addr  = addr;
    bus_if.data_sram_wdata = wdata;
    forever begin
      @(negedge clk);
      if (bus_if.data_sram_addr_ok) break;
      waited++;
      if (waited > 200) break;
    end
    checks++;
    if (waited > 200) begin
      failures++;
      $display("FAIL accept_timeout addr=%h got addr_ok=0 for 200 cycles want 1", addr);
    end else begin
      idx     = int'(addr[MEM_AW+1:2]);
      e.wr    = wr;
      e.idx   = idx;
      e.wstrb = wstrb;
      e.wdata = wdata;
      old_w   = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
      if (wr) begin
        e.rdata    = 32'h0;
        m_mem[idx] = apply_strb(old_w, wdata, wstrb);
      end else begin
        e.rdata = old_w;
      end
      e.exp_cyc = (cyc + LAT > last_exp + 1) ? cyc + LAT : last_exp + 1;
      last_exp  = e.exp_cyc;
      e.tag     = ntag++;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus_if.data_sram_req = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d responses outstanding want 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares outputs every cycle and retires scoreboard entries on data_ok.
  initial begin
    exp_t e;
    logic aok;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (bus_if.data_sram_addr_ok || bus_if.data_sram_data_ok || bus_if.data_sram_rdata != 32'h0) begin
          failures++;
          $display("FAIL reset_outputs got addr_ok=%b data_ok=%b rdata=%h want 0 0 0",
                   bus_if.data_sram_addr_ok, bus_if.data_sram_data_ok, bus_if.data_sram_rdata);
        end
        occ = 0;
      end else begin
        aok = bus_if.data_sram_addr_ok;
        checks++;
`ifdef RESP_STALL_EN
        if (aok && occ >= QDEPTH) begin
          failures++;
          $display("FAIL addr_ok_full got addr_ok=1 want 0 occupancy=%0d", occ);
        end
        if (!aok && occ < QDEPTH) stall_seen++;
`else
        if (aok != (occ < QDEPTH)) begin
          failures++;
          $display("FAIL addr_ok got %b want %b occupancy=%0d", aok, occ < QDEPTH, occ);
        end
`endif
        checks++;
        if (bus_if.data_sram_data_ok) begin
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL spurious_data_ok got data_ok=1 at cyc=%0d want no response", cyc);
          end else begin
            e = sb.pop_front();
            if (bus_if.data_sram_rdata !== e.rdata || cyc != e.exp_cyc) begin
              failures++;
              $display("FAIL resp tag=%0d got rdata=%h cyc=%0d want rdata=%h cyc=%0d",
                       e.tag, bus_if.data_sram_rdata, cyc, e.rdata, e.exp_cyc);
            end
            if (e.wr) begin
              c_mem[e.idx] = apply_strb(c_mem.exists(e.idx) ? c_mem[e.idx] : 32'h0, e.wdata, e.wstrb);
            end
            resp_n++;
          end
        end else if (bus_if.data_sram_rdata !== 32'h0) begin
          failures++;
          $display("FAIL idle_rdata got %h want 0", bus_if.data_sram_rdata);
        end
        if (bus_if.data_sram_req && aok) occ++;
        if (bus_if.data_sram_data_ok) occ--;
      end
    end
  end

  initial begin
    logic [31:0] a;
    int          idx;
    bus_if.data_sram_req   = 1'b0;
    bus_if.data_sram_wr    = 1'b0;
    bus_if.data_sram_size  = 2'd0;
    bus_if.data_sram_wstrb = 4'h0;
    bus_if.data_sram_addr  = 32'h0;
    bus_if.data_sram_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(1);

    // Preload words 0..16 (byte 0x00..0x40).
    for (int i = 0; i < NWORDS; i++) begin
      a = (i == 8) ? 32'h1122_3344 : (i == 16) ? 32'hCAFE_0040 : $urandom;
      issue(1'b1, 4'hF, 32'(i * 4), a);
    end
    drain();

    // Write then read back-to-back.
    issue(1'b1, 4'hF, 32'h10, 32'hA5A5_A5A5);
    issue(1'b0, 4'h0, 32'h10, 32'h0);
    drain();

    // Single-byte write merged into an existing word.
    issue(1'b1, 4'b0100, 32'h20, 32'hEEEE_EEEE);
    issue(1'b0, 4'h0, 32'h20, 32'h0);
    drain();

    // Requests held for six cycles: queue fills, addr_ok drops until the first pop.
    for (int i = 0; i < 6; i++) issue(1'b0, 4'h0, 32'(i * 4), 32'h0);
    drain();

    // Eight consecutive reads.
    for (int i = 0; i < 8; i++) issue(1'b0, 4'h0, 32'(32'h20 + i * 4), 32'h0);
    drain();

    // Reset with three entries pending, two of them writes to 0x40.
    issue(1'b1, 4'hF, 32'h40, 32'hDEAD_0001);
    issue(1'b0, 4'h0, 32'h40, 32'h0);
    issue(1'b1, 4'b0011, 32'h40, 32'h0000_BEEF);
    rst = 1'b1;
    #1;
    checks++;
    if (bus_if.data_sram_addr_ok || bus_if.data_sram_data_ok || bus_if.data_sram_rdata != 32'h0) begin
      failures++;
      $display("FAIL async_reset got addr_ok=%b data_ok=%b rdata=%h want 0 0 0",
               bus_if.data_sram_addr_ok, bus_if.data_sram_data_ok, bus_if.data_sram_rdata);
    end
    sb.delete();
    m_mem    = c_mem;
    last_exp = 0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle(LAT + 4);
    issue(1'b0, 4'h0, 32'h40, 32'h0);
    drain();

    // Random traffic with aliased high address bits and idle gaps.
    for (int n = 0; n < 100; n++) begin
      idx = $urandom_range(0, NWORDS - 1);
      a   = $urandom;
      a[MEM_AW+1:2] = MEM_AW'(idx);
      issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
      idle($urandom_range(0, 2));
    end
    drain();

`ifdef RESP_STALL_EN
    checks++;
    if (stall_seen == 0) begin
      failures++;
      $display("FAIL stall_seen got 0 stalled cycles with queue not full want >0");
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
